// File: rtl/bsg_clk_gen_pearl_freq_meter.sv
// rtl/bsg_clk_gen_pearl_freq_meter.sv - counts monitor-clock rising edges over a programmable clk_i window
// Optional build macro: BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN (yumi_i restarts the same window)
module bsg_clk_gen_pearl_freq_meter #(
    parameter int window_width_p = 16,
    parameter int count_width_p  = 16
) (
    input  logic                      clk_i,
    input  logic                      async_reset_n_i,
    input  logic                      mon_clk_i,
    input  logic [window_width_p-1:0] window_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      v_o,
    output logic [count_width_p-1:0]  count_o,
    output logic                      overflow_o,
    input  logic                      yumi_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [count_width_p-1:0] cnt_max_lp = '1;

    state_e                    state_r;
    logic                      sync1_r;
    logic                      sync2_r;
    logic                      hist_r;
    logic [window_width_p-1:0] win_r;
    logic [window_width_p-1:0] elapsed_r;
    logic [count_width_p-1:0]  cnt_r;
    logic                      ovf_r;
    logic                      edge_det;

    // An edge is a synchronized high whose previous sample was low.
    assign edge_det = sync2_r & ~hist_r;

    // Bring mon_clk_i into the clk_i domain and keep one cycle of history.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= mon_clk_i;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Measurement FSM: window timing, saturating edge counter, result hand-off.
    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_r   <= IDLE;
            win_r     <= '0;
            elapsed_r <= '0;
            cnt_r     <= '0;
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        win_r     <= window_i;
                        elapsed_r <= {{(window_width_p-1){1'b0}}, 1'b1};
                        cnt_r     <= '0;
                        ovf_r     <= 1'b0;
                        state_r   <= (window_i == '0) ? DONE : COUNT;
                    end
                end
                COUNT: begin
                    if (edge_det) begin
                        if (cnt_r == cnt_max_lp) begin
                            ovf_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                    // elapsed_r numbers the current window cycle, starting at 1
                    if (elapsed_r == win_r) begin
                        state_r <= DONE;
                    end else begin
                        elapsed_r <= elapsed_r + 1'b1;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
                        elapsed_r <= {{(window_width_p-1){1'b0}}, 1'b1};
                        cnt_r     <= '0;
                        ovf_r     <= 1'b0;
                        // a zero window has nothing to count and reports again at once
                        state_r   <= (win_r == '0) ? DONE : COUNT;
`else
                        state_r   <= IDLE;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Results are only presented while valid; otherwise they read as zero.
    always_comb begin
        busy_o     = (state_r != IDLE);
        v_o        = (state_r == DONE);
        count_o    = v_o ? cnt_r : '0;
        overflow_o = v_o ? ovf_r : 1'b0;
    end

endmodule

// File: tb/tb_bsg_clk_gen_pearl_freq_meter.sv
// tb/tb_bsg_clk_gen_pearl_freq_meter.sv - self-checking bench for bsg_clk_gen_pearl_freq_meter
module tb_bsg_clk_gen_pearl_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mon_clk = 1'b0;
    int          mon_half = 4;

    logic [15:0] window = '0;
    logic        start = 1'b0;
    logic        yumi = 1'b0;
    logic        busy, v, ovf;
    logic [15:0] cnt;

    logic [15:0] window4 = '0;
    logic        start4 = 1'b0;
    logic        yumi4 = 1'b0;
    logic        busy4, v4, ovf4;
    logic [3:0]  cnt4;

    int n_chk = 0;
    int n_pass = 0;

    bsg_clk_gen_pearl_freq_meter #(.window_width_p(16), .count_width_p(16)) u_dut (
        .clk_i(clk), .async_reset_n_i(rst_n), .mon_clk_i(mon_clk),
        .window_i(window), .start_i(start), .busy_o(busy), .v_o(v),
        .count_o(cnt), .overflow_o(ovf), .yumi_i(yumi)
    );

    bsg_clk_gen_pearl_freq_meter #(.window_width_p(16), .count_width_p(4)) u_dut4 (
        .clk_i(clk), .async_reset_n_i(rst_n), .mon_clk_i(mon_clk),
        .window_i(window4), .start_i(start4), .busy_o(busy4), .v_o(v4),
        .count_o(cnt4), .overflow_o(ovf4), .yumi_i(yumi4)
    );

    always #5 clk = ~clk;

    // Monitor clock, deliberately offset from clk so it is not edge-aligned.
    initial begin
        #3;
        forever begin
            #(mon_half * 10);
            mon_clk = ~mon_clk;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start on the main DUT and report cycles until v is seen.
    // With noise set, stray start/yumi are applied while the window runs.
    task automatic run_window(input int w, input bit noise, output int lat);
        window = w[15:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= w + 300; k++) begin
            if (v) begin
                lat = k;
                break;
            end
            if (noise) begin
                yumi = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                window = 16'($urandom);
            end
            tick();
            yumi = 1'b0;
            start = 1'b0;
        end
    endtask

    // Consume the result, with a random start alongside that must be ignored.
    task automatic consume(input string tag);
        yumi = 1'b1;
        start = 1'($urandom_range(0, 1));
        window = 16'($urandom);
        tick();
        yumi = 1'b0;
        start = 1'b0;
`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
        n_chk++; if (busy !== 1'b1) $display("FAIL %s_restart busy got %0b want 1", tag, busy); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`else
        n_chk++; if (v !== 1'b0) $display("FAIL %s_v_after_yumi got %0b want 0", tag, v); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL %s_busy_after_yumi got %0b want 0", tag, busy); else n_pass++;
        n_chk++; if (cnt !== 16'd0 || ovf !== 1'b0) $display("FAIL %s_zero_after_yumi got cnt=%0d ovf=%0b want 0/0", tag, cnt, ovf); else n_pass++;
`endif
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_chk++; if (v !== 1'b0) $display("FAIL reset_v got %0b want 0", v); else n_pass++;
        n_chk++; if (cnt !== 16'd0 || ovf !== 1'b0) $display("FAIL reset_outputs got cnt=%0d ovf=%0b want 0/0", cnt, ovf); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0 || v !== 1'b0) $display("FAIL reset_release got busy=%0b v=%0b want 0/0", busy, v); else n_pass++;
    endtask

    task automatic test_basic();
        int lat;
        mon_half = 4;
        repeat (20) tick();
        run_window(64, 1'b0, lat);
        n_chk++; if (lat !== 65) $display("FAIL basic_latency got %0d want 65", lat); else n_pass++;
        n_chk++; if (cnt < 16'd7 || cnt > 16'd9) $display("FAIL basic_count got %0d want 8+-1", cnt); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %0b want 0", ovf); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL basic_busy got %0b want 1", busy); else n_pass++;
        consume("basic");
    endtask

    task automatic test_random();
        int lat, w, p;
        for (int i = 0; i < 6; i++) begin
            mon_half = $urandom_range(2, 6);
            p = 2 * mon_half;
            w = $urandom_range(1, 200);
            repeat (20) tick();
            run_window(w, 1'b1, lat);
            n_chk++; if (lat !== w + 1) $display("FAIL rand%0d_latency got %0d want %0d", i, lat, w + 1); else n_pass++;
            // a window of w cycles holds floor or ceil of w/p monitor edges
            n_chk++; if (int'(cnt) * p < w - p || int'(cnt) * p > w + p) $display("FAIL rand%0d_count got %0d want about %0d/%0d", i, cnt, w, p); else n_pass++;
            n_chk++; if (ovf !== 1'b0) $display("FAIL rand%0d_ovf got %0b want 0", i, ovf); else n_pass++;
            consume("rand");
        end
    endtask

    task automatic test_zero();
        int lat;
        run_window(0, 1'b0, lat);
        n_chk++; if (lat !== 1) $display("FAIL zero_latency got %0d want 1", lat); else n_pass++;
        n_chk++; if (cnt !== 16'd0 || ovf !== 1'b0) $display("FAIL zero_result got cnt=%0d ovf=%0b want 0/0", cnt, ovf); else n_pass++;
`ifndef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
        yumi = 1'b1;
        start = 1'b1;
        window = 16'd5;
        tick();
        yumi = 1'b0;
        start = 1'b0;
        n_chk++; if (v !== 1'b0 || busy !== 1'b0) $display("FAIL zero_yumi_start got v=%0b busy=%0b want 0/0", v, busy); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL zero_start_ignored got busy=%0b want 0", busy); else n_pass++;
`else
        consume("zero");
`endif
    endtask

    task automatic test_hold();
        int lat, bad;
        logic [15:0] c0;
        logic o0;
        mon_half = 2;
        repeat (10) tick();
        run_window(40, 1'b0, lat);
        c0 = cnt;
        o0 = ovf;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            if (v !== 1'b1 || cnt !== c0 || ovf !== o0) bad++;
            tick();
        end
        n_chk++; if (bad !== 0) $display("FAIL hold_stable got %0d unstable cycles want 0", bad); else n_pass++;
        n_chk++; if (c0 < 16'd9 || c0 > 16'd11) $display("FAIL hold_count got %0d want 10+-1", c0); else n_pass++;
        consume("hold");
    endtask

    task automatic test_saturate();
        int lat, bad;
        window4 = 16'd100;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 400; k++) begin
            if (v4) begin
                lat = k;
                break;
            end
            tick();
        end
        n_chk++; if (lat !== 101) $display("FAIL sat_latency got %0d want 101", lat); else n_pass++;
        n_chk++; if (cnt4 !== 4'd15) $display("FAIL sat_count got %0d want 15", cnt4); else n_pass++;
        n_chk++; if (ovf4 !== 1'b1) $display("FAIL sat_ovf got %0b want 1", ovf4); else n_pass++;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (v4 !== 1'b1 || cnt4 !== 4'd15 || ovf4 !== 1'b1) bad++;
            tick();
        end
        n_chk++; if (bad !== 0) $display("FAIL sat_hold got %0d unstable cycles want 0", bad); else n_pass++;
        yumi4 = 1'b1;
        tick();
        yumi4 = 1'b0;
`ifndef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
        n_chk++; if (v4 !== 1'b0 || cnt4 !== 4'd0 || ovf4 !== 1'b0) $display("FAIL sat_after_yumi got v=%0b cnt=%0d ovf=%0b want 0/0/0", v4, cnt4, ovf4); else n_pass++;
`else
        n_chk++; if (v4 !== 1'b0 || busy4 !== 1'b1) $display("FAIL sat_restart got v=%0b busy=%0b want 0/1", v4, busy4); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        int lat, seen;
        mon_half = 3;
        window = 16'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || v !== 1'b0 || cnt !== 16'd0 || ovf !== 1'b0) $display("FAIL arst_immediate got busy=%0b v=%0b cnt=%0d ovf=%0b want all 0", busy, v, cnt, ovf); else n_pass++;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            if (v !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        n_chk++; if (seen !== 0) $display("FAIL arst_no_result got %0d active cycles want 0", seen); else n_pass++;
        run_window(20, 1'b0, lat);
        n_chk++; if (lat !== 21) $display("FAIL arst_restart_latency got %0d want 21", lat); else n_pass++;
        n_chk++; if (int'(cnt) * 6 < 14 || int'(cnt) * 6 > 26) $display("FAIL arst_restart_count got %0d want about 20/6", cnt); else n_pass++;
        consume("arst");
    endtask

`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
    task automatic test_continuous();
        int lat;
        mon_half = 2;
        repeat (10) tick();
        run_window(32, 1'b0, lat);
        for (int r = 0; r < 3; r++) begin
            n_chk++; if (cnt < 16'd7 || cnt > 16'd9) $display("FAIL cont%0d_count got %0d want 8+-1", r, cnt); else n_pass++;
            yumi = 1'b1;
            tick();
            yumi = 1'b0;
            n_chk++; if (v !== 1'b0 || busy !== 1'b1) $display("FAIL cont%0d_restart got v=%0b busy=%0b want 0/1", r, v, busy); else n_pass++;
            lat = 0;
            for (int k = 2; k <= 200; k++) begin
                tick();
                if (v) begin
                    lat = k;
                    break;
                end
            end
            n_chk++; if (lat !== 33) $display("FAIL cont%0d_latency got %0d want 33", r, lat); else n_pass++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_zero();
        test_hold();
        test_saturate();
        test_async_reset();
`ifdef BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN
        test_continuous();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bsg_clk_gen_pearl_freq_meter.md
BSG_CLK_GEN_PEARL_FREQ_METER -- requirements
Module: bsg_clk_gen_pearl_freq_meter

Interface
REQ-001 SHALL have parameter window_width_p, default 16, bit width of the measurement-window length in clk_i cycles.
REQ-002 SHALL have parameter count_width_p, default 16, bit width of the edge counter.
REQ-003 SHALL have port clk_i, input, 1, the single reference clock; all state is clocked on its rising edge.
REQ-004 SHALL have port async_reset_n_i, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port mon_clk_i, input, 1, the downsampled monitor clock from the clock generator, asynchronous to clk_i.
REQ-006 SHALL have port window_i, input, window_width_p, the window length, sampled only on an accepted start.
REQ-007 SHALL have port start_i, input, 1, the request to begin a measurement.
REQ-008 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-009 SHALL have port v_o, output, 1, result valid.
REQ-010 SHALL have port count_o, output, count_width_p, the number of mon_clk_i rising edges counted in the window.
REQ-011 SHALL have port overflow_o, output, 1, high when the counter saturated during the window.
REQ-012 SHALL have port yumi_i, input, 1, result consumed; legal only while v_o is high.

Function
REQ-013 SHALL pass mon_clk_i through a 2-flop synchronizer, then one history flop; an edge is sync=1 and history=0.
REQ-014 SHALL count correctly only when mon_clk_i high and low phases each last at least 2 clk_i periods; faster inputs undercount, and this is not an error.
REQ-015 SHALL implement the states IDLE, COUNT and DONE.
REQ-016 IDLE: when start_i is high in cycle t, SHALL latch window_i, clear the counter and overflow flag, and enter COUNT in cycle t+1.
REQ-017 COUNT: SHALL count edges detected in cycles t+1 through t+W inclusive, where W is the latched window.
REQ-018 COUNT: SHALL enter DONE so that v_o rises in cycle t+W+1.
REQ-019 W=0: SHALL go from IDLE directly to DONE, with v_o in cycle t+1, count_o=0 and overflow_o=0.
REQ-020 Counter SHALL saturate at 2^count_width_p-1; any further edge sets the overflow flag, which stays set until the next accepted start.
REQ-021 DONE: count_o and overflow_o SHALL hold stable while v_o=1; v_o SHALL stay high until yumi_i.
REQ-022 yumi_i in DONE SHALL return the block to IDLE in the next cycle, with v_o low.
REQ-023 start_i SHALL be ignored in COUNT and DONE, including when it coincides with yumi_i.
REQ-024 yumi_i outside DONE SHALL have no effect.
REQ-025 count_o and overflow_o SHALL be 0 whenever v_o=0.

Reset
REQ-026 async_reset_n_i low SHALL immediately force IDLE, clear the synchronizer, history, counter, window and overflow flops, and drive busy_o=0, v_o=0, count_o=0 and overflow_o=0.
REQ-027 Reset mid-COUNT or mid-DONE SHALL discard the measurement, and no v_o pulse SHALL follow.
REQ-028 After deassertion, the first start_i SHALL be accepted on the first clk_i rising edge at which reset is high.
REQ-029 Deassertion SHALL be treated as synchronous to clk_i; the reset synchronizer is the integrator's responsibility.

Configuration
REQ-030 With BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN defined, yumi_i in DONE SHALL go directly to COUNT with the previously latched window and a cleared counter and overflow flag, ignoring start_i and window_i.
REQ-031 Without BSG_CLK_GEN_PEARL_FREQ_METER_CONTINUOUS_EN, yumi_i in DONE SHALL return the block to IDLE as in REQ-022.
REQ-032 In either build, a reset SHALL return the block to IDLE.

Verification
REQ-033 mon_clk_i period 8 clk_i cycles, W=64, start pulse -> v_o 65 cycles later, count_o of 8 (tolerance ±1), overflow_o=0.
REQ-034 count_width_p=4, mon_clk_i period 4, W=100 -> count_o=15, overflow_o=1, and both hold until yumi_i.
REQ-035 W=0 -> v_o next cycle with count_o=0; yumi_i together with start_i -> IDLE, and start_i is not accepted.
REQ-036 async_reset_n_i pulsed low at cycle 10 of a W=50 window -> outputs go 0 immediately, no v_o follows, and a new W=20 start completes normally.
REQ-037 v_o held 30 cycles without yumi_i -> count_o and overflow_o stable; yumi_i -> v_o low and busy_o low the next cycle.
REQ-038 With CONTINUOUS_EN, W=32 and mon_clk_i period 4, three consecutive yumi_i -> three results, each count_o of 8 (tolerance ±1), with no start_i after the first.
